// File: rtl/fp_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_disp_pkg
// Description : Shared types and constants for the floating-point display
//               stage: FSM states, digit/iteration counts and active-low
//               seven-segment glyphs ({g,f,e,d,c,b,a}).
// Revision    : 1.0 - initial release
// ============================================================================
package fp_disp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int CONV_ITERS = 11;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;

    // Hex nibble to active-low segment pattern
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = SEG_0;
            4'h1: r = SEG_1;
            4'h2: r = SEG_2;
            4'h3: r = SEG_3;
            4'h4: r = SEG_4;
            4'h5: r = SEG_5;
            4'h6: r = SEG_6;
            4'h7: r = SEG_7;
            4'h8: r = SEG_8;
            4'h9: r = SEG_9;
            4'hA: r = SEG_A;
            4'hB: r = SEG_B;
            4'hC: r = SEG_C;
            4'hD: r = SEG_D;
            4'hE: r = SEG_E;
            default: r = SEG_F;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble, one shift per cycle, 11-bit binary
//               to four BCD nibbles. bcd carries the final result during the
//               cycle in which done is high (it is the post-shift value that
//               the register is about to take).
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import fp_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    logic [10:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_busy;

    logic [15:0] w_adj;
    logic [15:0] w_bcd_next;
    logic [10:0] w_bin_next;

    // Add-3 correction on every nibble >= 5, then shift {bcd,bin} left by one
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
        {w_bcd_next, w_bin_next} = {w_adj, r_bin} << 1;
    end

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == 4'(CONV_ITERS - 1));
    assign bcd  = w_bcd_next;

    // Load operand on start, then iterate until the last shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= 4'd0;
            r_bin  <= 11'd0;
            r_bcd  <= 16'd0;
        end else if (r_busy) begin
            r_bin <= w_bin_next;
            r_bcd <= w_bcd_next;
            r_cnt <= r_cnt + 4'd1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end else if (start) begin
            r_bin  <= bin;
            r_bcd  <= 16'd0;
            r_cnt  <= 4'd0;
            r_busy <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_seg_display.sv
`default_nettype none
// ============================================================================
// Module      : fp_seg_display
// Description : Captures converter S/E/F, converts F*2^E to BCD and scans
//               four active-low seven-segment digits; mode selects decimal
//               magnitude or raw field view.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_seg_display
    import fp_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       s,
    input  logic [2:0] e,
    input  logic [3:0] f,
    input  logic       mode,
    output logic       busy,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    state_t r_state;
    state_t w_state_next;
    logic   w_start;
    logic   w_commit;

    logic       r_stg_s;
    logic [2:0] r_stg_e;
    logic [3:0] r_stg_f;

    logic [15:0] r_disp_bcd;
    logic        r_disp_s;
    logic [2:0]  r_disp_e;
    logic [3:0]  r_disp_f;

    logic [CNT_W-1:0] r_refresh;
    logic [IDX_W-1:0] r_idx;
    logic             w_wrap;

    logic        w_conv_busy;
    logic        w_done;
    logic [15:0] w_bcd;
    logic [10:0] w_v;

    logic [6:0] w_seg;
    logic       w_dp;
    logic [3:0] w_an;

    assign w_v  = {7'b0, f} << e;
    assign busy = w_conv_busy;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (w_v),
        .busy  (w_conv_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: loads accepted only in IDLE; commit on the final iteration
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_start      = 1'b1;
                    w_state_next = CONV;
                end
            end
            CONV: begin
                if (w_done) begin
                    w_commit     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Staging at load, atomic display update at commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_s    <= 1'b0;
            r_stg_e    <= 3'd0;
            r_stg_f    <= 4'd0;
            r_disp_bcd <= 16'd0;
            r_disp_s   <= 1'b0;
            r_disp_e   <= 3'd0;
            r_disp_f   <= 4'd0;
        end else begin
            if (w_start) begin
                r_stg_s <= s;
                r_stg_e <= e;
                r_stg_f <= f;
            end
            if (w_commit) begin
                r_disp_bcd <= w_bcd;
                r_disp_s   <= r_stg_s;
                r_disp_e   <= r_stg_e;
                r_disp_f   <= r_stg_f;
            end
        end
    end

    assign w_wrap = (r_refresh == CNT_W'(REFRESH_DIV - 1));

    // Refresh counter and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else if (w_wrap) begin
            r_refresh <= '0;
            r_idx     <= r_idx + 1'b1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // Segment selection for the current digit; leading zeros blanked
    always_comb begin
        w_seg = BLANK;
        w_dp  = 1'b1;
        w_an  = ~(4'b0001 << r_idx);
        if (!mode) begin
            case (r_idx)
                2'd3: if (r_disp_bcd[15:12] != 4'd0) w_seg = hex_to_seg(r_disp_bcd[15:12]);
                2'd2: if (r_disp_bcd[15:8] != 8'd0)  w_seg = hex_to_seg(r_disp_bcd[11:8]);
                2'd1: if (r_disp_bcd[15:4] != 12'd0) w_seg = hex_to_seg(r_disp_bcd[7:4]);
                default: w_seg = hex_to_seg(r_disp_bcd[3:0]);
            endcase
            // Sign shown on the leftmost dp; negative zero stays unsigned
            if ((r_idx == 2'd3) && r_disp_s && (r_disp_bcd != 16'd0)) begin
                w_dp = 1'b0;
            end
        end else begin
            case (r_idx)
                2'd3: if (r_disp_s) w_seg = MINUS;
                2'd2: w_seg = hex_to_seg({1'b0, r_disp_e});
                2'd1: w_seg = hex_to_seg(r_disp_f);
                default: w_seg = BLANK;
            endcase
        end
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= BLANK;
            dp  <= 1'b1;
            an  <= 4'b1111;
        end else begin
            seg <= w_seg;
            dp  <= w_dp;
            an  <= w_an;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_seg_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_seg_display
// Description : Scoreboard bench for fp_seg_display (REFRESH_DIV=4). Stimulus
//               pushes the expected committed fields; a monitor pops them on
//               each busy fall and checks every scanned digit against a
//               decimal/hex reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_seg_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       s = 1'b0;
    logic [2:0] e = 3'd0;
    logic [3:0] f = 4'd0;
    logic       mode = 1'b0;
    logic       busy;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    typedef struct {
        logic       s;
        logic [2:0] e;
        logic [3:0] f;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad   = 0;

    fp_seg_display #(.REFRESH_DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .s    (s),
        .e    (e),
        .f    (f),
        .mode (mode),
        .busy (busy),
        .seg  (seg),
        .dp   (dp),
        .an   (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_hex(input int v);
        case (v)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Expected {dp_n, seg} for digit k of a committed value under a mode
    function automatic logic [7:0] ref_digit(input item_t it, input logic m, input int k);
        int         mag;
        int         p;
        logic [6:0] sg;
        logic       dpn;
        mag = int'(it.f) * (1 << it.e);
        sg  = 7'b1111111;
        dpn = 1'b1;
        if (!m) begin
            p = 1;
            for (int i = 0; i < k; i++) p = p * 10;
            if (k == 0 || mag >= p) sg = ref_hex((mag / p) % 10);
            if (k == 3 && it.s && mag != 0) dpn = 1'b0;
        end else begin
            if (k == 3 && it.s) sg = 7'b0111111;
            if (k == 2) sg = ref_hex(int'(it.e));
            if (k == 1) sg = ref_hex(int'(it.f));
        end
        return {dpn, sg};
    endfunction

    // Monitor: checks outputs each cycle, consumes scoreboard on commit
    initial begin : monitor
        logic       rst_p;
        logic       mode_p;
        logic       armed;
        int         c;
        int         blen;
        int         idx;
        logic [3:0] exp_an;
        logic [7:0] exp_d;
        item_t      cur;
        rst_p  = 1'b0;
        mode_p = 1'b0;
        armed  = 1'b0;
        c      = 0;
        blen   = 0;
        cur    = '{1'b0, 3'd0, 4'd0};
        forever begin
            @(negedge clk);
            if (armed) begin
                if (rst_p) begin
                    check("rst_an", int'(an), 'hF);
                    check("rst_seg", int'(seg), 'h7F);
                    check("rst_dp", int'(dp), 1);
                    check("rst_busy", int'(busy), 0);
                    c    = 0;
                    blen = 0;
                    q.delete();
                    cur  = '{1'b0, 3'd0, 4'd0};
                end else begin
                    idx    = (c / DIV) % 4;
                    exp_an = ~(4'b0001 << idx);
                    check("scan_an", int'(an), int'(exp_an));
                    exp_d = ref_digit(cur, mode_p, idx);
                    check("seg", int'(seg), int'(exp_d[6:0]));
                    check("dp", int'(dp), int'(exp_d[7]));
                    c++;
                    if (busy) begin
                        blen++;
                    end else if (blen > 0) begin
                        check("busy_len", blen, 11);
                        check("commit_pending", int'(q.size() > 0), 1);
                        if (q.size() > 0) cur = q.pop_front();
                        blen = 0;
                    end
                end
            end
            if (rst) armed = 1'b1;
            rst_p  = rst;
            mode_p = mode;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Drive a one-cycle load; push the expected commit only if it should be taken
    task automatic do_load(input logic ss, input int ee, input int ff, input logic push);
        item_t it;
        it   = '{ss, 3'(ee), 4'(ff)};
        load = 1'b1;
        s    = ss;
        e    = 3'(ee);
        f    = 4'(ff);
        if (push) q.push_back(it);
        tick();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    initial begin : stimulus
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(20);

        // 416, then 1920 negative
        mode = 1'b0;
        do_load(1'b0, 5, 13, 1'b1);
        wait_idle();
        idle(18);
        do_load(1'b1, 7, 15, 1'b1);
        wait_idle();
        idle(18);

        // Loads during conversion and on the commit edge are ignored
        do_load(1'b0, 5, 13, 1'b1);
        idle(2);
        do_load(1'b0, 0, 1, 1'b0);
        idle(7);
        do_load(1'b1, 1, 1, 1'b0);
        wait_idle();
        idle(18);

        // Raw field view, then back to decimal on the same value
        mode = 1'b1;
        do_load(1'b1, 3, 10, 1'b1);
        wait_idle();
        idle(18);
        mode = 1'b0;
        idle(18);

        // Negative zero shows no sign
        do_load(1'b1, 4, 0, 1'b1);
        wait_idle();
        idle(18);

        // Reset in the 5th busy cycle aborts; fresh load afterwards
        do_load(1'b0, 5, 13, 1'b1);
        idle(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(18);
        do_load(1'b0, 0, 9, 1'b1);
        wait_idle();
        idle(18);

        // Random values with mode toggling
        for (int i = 0; i < 12; i++) begin
            mode = 1'($urandom_range(0, 1));
            do_load(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 15)), 1'b1);
            wait_idle();
            idle(18);
            mode = ~mode;
            idle(18);
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_seg_display.md
# fp_seg_display

Downstream display stage for the floating-point converter. Captures the converter's sign/exponent/significand result (S, E, F) on a load strobe, reconstructs the magnitude F·2^E, and converts it to BCD with a sequential double-dabble. It then time-multiplexes four active-low seven-segment digits on the board. A mode input selects between the decimal magnitude and the raw S/E/F fields.

## Interface
- REFRESH_DIV, 65536: clock cycles each digit stays selected; must be ≥2.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe; captures s/e/f when idle
- s  in  1  sign from converter
- e  in  3  exponent from converter
- f  in  4  significand from converter
- mode  in  1  0 = decimal magnitude, 1 = raw fields
- busy  out  1  high while a conversion is in progress
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- dp  out  1  active-low decimal point
- an  out  4  active-low digit enables; an[0] is the rightmost digit

## Operation
- Load: in IDLE, `load`=1 at a rising edge does the following:
  - latches s, e, f into staging registers;
  - sets the 11-bit shift register to V = {7'b0,f} << e (max 15·128 = 1920);
  - clears the 16-bit BCD register and the iteration counter;
  - enters CONV and sets busy=1.
- `load` is ignored while in CONV; no queueing.
- CONV: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,V} left by one. After the 11th shift, the display registers take BCD digits 3..0 and the staged s/e/f in the same edge (atomic commit), then the FSM returns to IDLE with busy=0.
- FSM states: IDLE → CONV on load; CONV → IDLE on the 11th iteration; any state → IDLE on rst.
- Display registers keep the previous result until commit. There are no partial updates.
- Decimal mode (mode=0):
  - Digits 3..0 show the BCD value.
  - Leading zeros are blanked, except that digit0 is always shown.
  - dp is lit on digit3 only when committed s=1 and magnitude ≠0, so negative zero shows no sign.
- Raw mode (mode=1):
  - digit3 shows '-' if s=1, otherwise blank.
  - digit2 shows E in hex.
  - digit1 shows F in hex (0-F).
  - digit0 is blank.
  - dp is off.
- Scanning:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index advances 0→1→2→3→0.
  - Exactly one `an` bit is low at any time after reset.
- Outputs seg/dp/an are registered and are a function of the index, mode and display registers from the previous cycle.

## Timing
- Reset values:
  - busy=0, an=4'b1111, seg=7'b1111111, dp=1;
  - display registers and staging all 0; index=0; refresh counter=0; state IDLE.
- First cycle after rst deasserts: an=1110, seg shows "0".
- Load latency: a load sampled at edge 0 gives busy=1 after edge 0 through edge 10. The commit happens at edge 11, where busy falls. The new value appears on seg at edge 12, for whichever digit is currently selected.
- A load in the same cycle as commit (busy still 1) is ignored.
- rst mid-conversion aborts the conversion. The display returns to its reset values, and the staged data is discarded.
- Mode change takes effect on seg/dp one cycle later; it does not restart scanning or conversion.
- Digit period is REFRESH_DIV cycles; the full frame is 4·REFRESH_DIV.

## Structure
- Package fp_disp_pkg holds:
  - the state enum (IDLE, CONV);
  - NUM_DIGITS=4 and CONV_ITERS=11;
  - active-low segment constants for 0-9, A-F, BLANK=7'b1111111 and MINUS=7'b0111111.
- Sub-module bin2bcd_seq: 11-bit start/busy/done sequential double-dabble producing four BCD nibbles. The top level holds the FSM wrapper, staging and display registers, refresh counter, and the segment mux/decoder.

## Test plan
Run with REFRESH_DIV=4.
1. Reset/scan: hold rst 2 cycles, then release.
   - During reset: an=1111, seg=1111111, dp=1, busy=0.
   - After release: the an sequence is 1110,1101,1011,0111,1110, each held 4 cycles.
   - On an=1110 seg=1000000; the other digits are blank.
2. Load s=0, e=5, f=13 (416):
   - busy is high for exactly 11 cycles.
   - digit2 shows 0011001 ('4'), digit1 1111001 ('1'), digit0 0000010 ('6').
   - digit3 is blank; dp=1 throughout.
3. Load s=1, e=7, f=15 (1920): digit3 shows '1' (1111001) with dp=0 on an=0111 only; the remaining digits are '9','2','0'.
4. Load 416, then a second load (s=0, e=0, f=1) 3 cycles later: the second load is ignored, and the display settles to 416 at edge 12.
5. mode=1 with committed s=1, e=3, f=10: digit3 shows 0111111, digit2 0110000, digit1 0001000, and digit0 is blank.
6. Assert rst during the 5th busy cycle:
   - next cycle busy=0 and an=1111;
   - after release the display shows "0";
   - a fresh load of e=0, f=9 then displays '9'.
